// File: rtl/eth_tx_fcs_pkg.sv
// Shared constants and state encoding for the Ethernet transmit framer and
// its CRC-32 byte engine.
package eth_tx_fcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_FCS  = 3'd4
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [2:0]  PREAMBLE_LEN  = 3'd7;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [10:0] COUNT_MAX     = 11'h7FF;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (data consumed LSB first).
module eth_crc32_byte
  import eth_tx_fcs_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
    end
  end

  assign crc_out = acc;

endmodule

// File: rtl/eth_tx_fcs.sv
// Ethernet transmit framer: optional preamble/SFD, payload pass-through,
// zero padding to a minimum length and FCS append, behind one output register.
module eth_tx_fcs
  import eth_tx_fcs_pkg::*;
#(
  parameter int MIN_FRAME   = 60,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic       eth_clk,
  input  logic       eth_rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int          MIN_SAT = (MIN_FRAME > 2047) ? 2047 : MIN_FRAME;
  localparam logic [11:0] MIN_CNT = MIN_SAT[11:0];

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [10:0] count_q, count_d, count_inc;
  logic [2:0]  phase_q, phase_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, frame_done_q;
  logic        load, s_accept, xfer_last, pad_more;
  logic [7:0]  crc_byte;

  assign load      = !m_valid_q || m_ready;
  assign s_ready   = (state_q == ST_DATA) && load;
  assign s_accept  = s_valid && s_ready;
  assign xfer_last = m_valid_q && m_ready && m_last_q;
  assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 11'd1;
  // Still short of the minimum after this byte; written as +1 <= so that a
  // zero minimum never produces a constant comparison.
  assign pad_more  = ({1'b0, count_inc} + 12'd1) <= MIN_CNT;
  assign crc_byte  = (state_q == ST_PAD) ? 8'h00 : s_data;

  eth_crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    count_d   = count_q;
    phase_d   = phase_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (load) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        crc_d   = CRC_INIT;
        count_d = '0;
        phase_d = '0;
        if (s_valid && load) begin
          if (PREAMBLE_EN) begin
            // First preamble byte goes out immediately so a back-to-back
            // frame starts on the cycle after frame_done.
            state_d   = ST_PRE;
            m_valid_d = 1'b1;
            m_data_d  = PREAMBLE_BYTE;
            phase_d   = 3'd1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_PRE: begin
        if (load) begin
          m_valid_d = 1'b1;
          if (phase_q == PREAMBLE_LEN) begin
            m_data_d = SFD_BYTE;
            phase_d  = '0;
            state_d  = ST_DATA;
          end else begin
            m_data_d = PREAMBLE_BYTE;
            phase_d  = phase_q + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          crc_d     = crc_next;
          count_d   = count_inc;
          if (s_last) state_d = pad_more ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if (load) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'h00;
          crc_d     = crc_next;
          count_d   = count_inc;
          if (!pad_more) state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        // Phases 0..3 load the FCS bytes; phase 4 waits for the last one to leave.
        if (phase_q < 3'd4) begin
          if (load) begin
            m_valid_d = 1'b1;
            m_last_d  = (phase_q == 3'd3);
            phase_d   = phase_q + 3'd1;
            case (phase_q[1:0])
              2'd0:    m_data_d = ~crc_q[7:0];
              2'd1:    m_data_d = ~crc_q[15:8];
              2'd2:    m_data_d = ~crc_q[23:16];
              default: m_data_d = ~crc_q[31:24];
            endcase
          end
        end else if (xfer_last) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      count_q      <= '0;
      phase_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      count_q      <= count_d;
      phase_q      <= phase_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= xfer_last;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Directed bench for eth_tx_fcs: one instance without preamble/padding, one
// with default parameters; output bytes are captured and checked per scenario.
module tb_eth_tx_fcs;

  logic clk, rst;

  logic       aValid, aLast, aReady, aMValid, aMLast, aMReady, aBusy, aDone;
  logic [7:0] aData, aMData;
  logic       bValid, bLast, bReady, bMValid, bMLast, bMReady, bBusy, bDone;
  logic [7:0] bData, bMData;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic toggleB = 1'b0;

  logic [7:0] txBuf [0:255];
  logic       txLast[0:255];
  logic [8:0] expQ[$];

  logic [8:0] capA[$], capB[$];
  int cycA[$], cycB[$], doneA[$], doneB[$];
  int holdErrB = 0;
  int stallSeenB = 0;
  logic prevStallB = 1'b0;
  logic [8:0] prevB = '0;

  eth_tx_fcs #(.MIN_FRAME(0), .PREAMBLE_EN(1'b0)) dutA (
    .eth_clk(clk), .eth_rst(rst),
    .s_valid(aValid), .s_data(aData), .s_last(aLast), .s_ready(aReady),
    .m_valid(aMValid), .m_data(aMData), .m_last(aMLast), .m_ready(aMReady),
    .busy(aBusy), .frame_done(aDone)
  );

  eth_tx_fcs dutB (
    .eth_clk(clk), .eth_rst(rst),
    .s_valid(bValid), .s_data(bData), .s_last(bLast), .s_ready(bReady),
    .m_valid(bMValid), .m_data(bMData), .m_last(bMLast), .m_ready(bMReady),
    .busy(bBusy), .frame_done(bDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bMReady = toggleB ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (aMValid && aMReady) begin
        capA.push_back({aMLast, aMData});
        cycA.push_back(cyc);
      end
      if (aDone) doneA.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prevStallB <= 1'b0;
    end else begin
      if (bMValid && bMReady) begin
        capB.push_back({bMLast, bMData});
        cycB.push_back(cyc);
      end
      if (bDone) doneB.push_back(cyc);
      if (prevStallB && (!bMValid || {bMLast, bMData} !== prevB)) holdErrB <= holdErrB + 1;
      if (bMValid && !bMReady) stallSeenB <= stallSeenB + 1;
      prevStallB <= bMValid && !bMReady;
      prevB      <= {bMLast, bMData};
    end
  end

  // Bytes leave CRC bit-serially here, independent of the byte-wide RTL form.
  function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic appendFrame(input bit pre, input int minFrame, input int start, input int len);
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    if (pre) begin
      for (int i = 0; i < 7; i++) expQ.push_back({1'b0, 8'h55});
      expQ.push_back({1'b0, 8'hD5});
    end
    for (int i = start; i < start + len; i++) begin
      expQ.push_back({1'b0, txBuf[i]});
      c = crcStep(c, txBuf[i]);
    end
    n = len;
    while (n < minFrame) begin
      expQ.push_back({1'b0, 8'h00});
      c = crcStep(c, 8'h00);
      n++;
    end
    c = ~c;
    expQ.push_back({1'b0, c[7:0]});
    expQ.push_back({1'b0, c[15:8]});
    expQ.push_back({1'b0, c[23:16]});
    expQ.push_back({1'b1, c[31:24]});
  endtask

  task automatic setSrc(input int inst, input logic v, input logic [7:0] d, input logic l);
    if (inst == 0) begin aValid = v; aData = d; aLast = l; end
    else begin bValid = v; bData = d; bLast = l; end
  endtask

  task automatic sendFrame(input int inst, input int len, input int gapAt, input int gapLen,
                           output bit ok);
    int waited;
    logic accepted;
    ok = 1'b1;
    for (int i = 0; i < len && ok; i++) begin
      if (i == gapAt) begin
        setSrc(inst, 1'b0, 8'h00, 1'b0);
        repeat (gapLen) @(posedge clk);
        #1;
      end
      setSrc(inst, 1'b1, txBuf[i], txLast[i]);
      waited = 0;
      accepted = 1'b0;
      while (!accepted && waited < 2000) begin
        @(negedge clk);
        accepted = (inst == 0) ? aReady : bReady;
        waited++;
      end
      if (!accepted) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    setSrc(inst, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitFrames(input int inst, input int target, input int maxCyc);
    int n;
    n = 0;
    while (((inst == 0) ? doneA.size() : doneB.size()) < target && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aValid = 1'b1;
    bValid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({aMValid, aMData, aMLast, aReady, aBusy, aDone} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_a: got %h required 0", {aMValid, aMData, aMLast, aReady, aBusy, aDone});
    end
    checks++;
    if ({bMValid, bMData, bMLast, bReady, bBusy, bDone} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_b: got %h required 0", {bMValid, bMData, bMLast, bReady, bBusy, bDone});
    end
    aValid = 1'b0;
    bValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bBusy, bMValid, aBusy, aMValid} !== 4'h0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b required 0000", {bBusy, bMValid, aBusy, aMValid});
    end
  endtask

  task automatic test_check_value();
    int base, dbase, bad, firstBad;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      txBuf[i]  = 8'(8'h31 + i);
      txLast[i] = (i == 8);
    end
    base  = capA.size();
    dbase = doneA.size();
    sendFrame(0, 9, -1, 0, ok);
    waitFrames(0, dbase + 1, 200);
    expQ.delete();
    for (int i = 0; i < 9; i++) expQ.push_back({1'b0, txBuf[i]});
    expQ.push_back({1'b0, 8'h26});
    expQ.push_back({1'b0, 8'h39});
    expQ.push_back({1'b0, 8'hF4});
    expQ.push_back({1'b1, 8'hCB});
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL check_src_timeout: got stuck required accepted"); end
    checks++;
    if (capA.size() - base != 13) begin
      errors++;
      $display("[TB] FAIL check_len: got %0d required 13", capA.size() - base);
    end
    bad = 0; firstBad = -1;
    for (int i = 0; i < 13; i++)
      if (base + i >= capA.size() || capA[base + i] !== expQ[i]) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL check_stream: %0d bad, first at %0d got %h required %h",
               bad, firstBad, capA[base + firstBad], expQ[firstBad]);
    end
    checks++;
    if (doneA.size() <= dbase || capA.size() < base + 13 || doneA[dbase] != cycA[base + 12] + 1) begin
      errors++;
      $display("[TB] FAIL check_done_timing: got %0d pulses required one at last+1", doneA.size() - dbase);
    end
    checks++;
    if (aBusy !== 1'b0) begin errors++; $display("[TB] FAIL check_busy_end: got %b required 0", aBusy); end
  endtask

  task automatic test_gap();
    int base, dbase, bad;
    bit ok;
    base  = capA.size();
    dbase = doneA.size();
    sendFrame(0, 9, 4, 3, ok);
    waitFrames(0, dbase + 1, 200);
    checks++;
    if (!ok || capA.size() - base != 13) begin
      errors++;
      $display("[TB] FAIL gap_len: got %0d required 13", capA.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 13; i++)
      if (base + i >= capA.size() || capA[base + i] !== expQ[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL gap_stream: got %0d bad bytes required 0", bad); end
    checks++;
    if (cycA[base + 4] - cycA[base + 3] != 4) begin
      errors++;
      $display("[TB] FAIL gap_stall: got spacing %0d required 4", cycA[base + 4] - cycA[base + 3]);
    end
  endtask

  task automatic test_min_pad();
    int base, dbase, bad;
    bit ok;
    txBuf[0]  = 8'hFF;
    txLast[0] = 1'b1;
    base  = capB.size();
    dbase = doneB.size();
    sendFrame(1, 1, -1, 0, ok);
    waitFrames(1, dbase + 1, 400);
    expQ.delete();
    appendFrame(1'b1, 60, 0, 1);
    checks++;
    if (!ok || capB.size() - base != 72) begin
      errors++;
      $display("[TB] FAIL pad_len: got %0d required 72", capB.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 72; i++)
      if (base + i >= capB.size() || capB[base + i] !== expQ[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL pad_stream: got %0d bad bytes required 0", bad); end
    checks++;
    if (doneB.size() - dbase != 1) begin
      errors++;
      $display("[TB] FAIL pad_done_count: got %0d required 1", doneB.size() - dbase);
    end
  endtask

  task automatic test_stall();
    int base, dbase, bad, holdBase, stallBase;
    bit ok1, ok2;
    logic [8:0] run1[$];
    for (int i = 0; i < 64; i++) begin
      txBuf[i]  = 8'(i * 37 + 5);
      txLast[i] = (i == 63);
    end
    expQ.delete();
    appendFrame(1'b1, 60, 0, 64);
    base  = capB.size();
    dbase = doneB.size();
    sendFrame(1, 64, -1, 0, ok1);
    waitFrames(1, dbase + 1, 400);
    for (int i = base; i < capB.size(); i++) run1.push_back(capB[i]);
    bad = (run1.size() == 76) ? 0 : 1;
    for (int i = 0; i < 76 && i < run1.size(); i++) if (run1[i] !== expQ[i]) bad++;
    checks++;
    if (!ok1 || bad != 0) begin errors++; $display("[TB] FAIL stall_ref_stream: got %0d bad required 0", bad); end

    holdBase  = holdErrB;
    stallBase = stallSeenB;
    base  = capB.size();
    dbase = doneB.size();
    toggleB = 1'b1;
    sendFrame(1, 64, -1, 0, ok2);
    waitFrames(1, dbase + 1, 2000);
    toggleB = 1'b0;
    bad = (capB.size() - base == run1.size()) ? 0 : 1;
    for (int i = 0; i < run1.size() && base + i < capB.size(); i++) if (capB[base + i] !== run1[i]) bad++;
    checks++;
    if (!ok2 || bad != 0) begin errors++; $display("[TB] FAIL stall_stream: got %0d bad required 0", bad); end
    checks++;
    if (holdErrB - holdBase != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got %0d changes while stalled required 0", holdErrB - holdBase);
    end
    checks++;
    if (stallSeenB - stallBase == 0) begin errors++; $display("[TB] FAIL stall_seen: got 0 stalls required >0"); end
  endtask

  task automatic test_back_to_back();
    int base, dbase, bad;
    bit ok;
    txBuf[0] = 8'h11; txBuf[1] = 8'h22; txBuf[2] = 8'h33;
    txBuf[3] = 8'hA0; txBuf[4] = 8'hA1;
    for (int i = 0; i < 5; i++) txLast[i] = (i == 2) || (i == 4);
    expQ.delete();
    appendFrame(1'b1, 60, 0, 3);
    appendFrame(1'b1, 60, 3, 2);
    base  = capB.size();
    dbase = doneB.size();
    sendFrame(1, 5, -1, 0, ok);
    waitFrames(1, dbase + 2, 600);
    checks++;
    if (!ok || capB.size() - base != 144) begin
      errors++;
      $display("[TB] FAIL b2b_len: got %0d required 144", capB.size() - base);
    end
    bad = 0;
    for (int i = 0; i < 144; i++)
      if (base + i >= capB.size() || capB[base + i] !== expQ[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL b2b_stream: got %0d bad bytes required 0", bad); end
    checks++;
    if (doneB.size() - dbase != 2) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: got %0d required 2", doneB.size() - dbase);
    end
    checks++;
    if (doneB.size() < dbase + 1 || capB.size() < base + 73 || cycB[base + 72] != doneB[dbase] + 1) begin
      errors++;
      $display("[TB] FAIL b2b_preamble_start: got cycle %0d required %0d", cycB[base + 72], doneB[dbase] + 1);
    end
    checks++;
    if (doneB.size() < dbase + 2 || capB.size() < base + 144 || doneB[dbase + 1] != cycB[base + 143] + 1) begin
      errors++;
      $display("[TB] FAIL b2b_done_timing: second pulse not one cycle after last byte");
    end
  endtask

  task automatic test_reset_mid();
    int base, dbase, bad;
    bit ok;
    for (int i = 0; i < 20; i++) begin
      txBuf[i]  = 8'(i);
      txLast[i] = 1'b0;
    end
    sendFrame(0, 20, -1, 0, ok);
    checks++;
    if (!ok || {aMValid, aBusy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL abort_midframe: got valid/busy %b required 11", {aMValid, aBusy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({aMValid, aMData, aMLast, aReady, aBusy, aDone} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL abort_async_clear: got %h required 0", {aMValid, aMData, aMLast, aReady, aBusy, aDone});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    base  = capA.size();
    dbase = doneA.size();
    repeat (10) @(negedge clk);
    checks++;
    if (capA.size() != base || doneA.size() != dbase) begin
      errors++;
      $display("[TB] FAIL abort_no_fcs: got %0d bytes required 0", capA.size() - base);
    end
    for (int i = 0; i < 9; i++) begin
      txBuf[i]  = 8'(8'h31 + i);
      txLast[i] = (i == 8);
    end
    sendFrame(0, 9, -1, 0, ok);
    waitFrames(0, dbase + 1, 200);
    expQ.delete();
    for (int i = 0; i < 9; i++) expQ.push_back({1'b0, txBuf[i]});
    expQ.push_back({1'b0, 8'h26});
    expQ.push_back({1'b0, 8'h39});
    expQ.push_back({1'b0, 8'hF4});
    expQ.push_back({1'b1, 8'hCB});
    bad = (capA.size() - base == 13) ? 0 : 1;
    for (int i = 0; i < 13; i++)
      if (base + i >= capA.size() || capA[base + i] !== expQ[i]) bad++;
    checks++;
    if (!ok || bad != 0) begin errors++; $display("[TB] FAIL abort_next_frame: got %0d bad required 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    aValid = 1'b0; aData = 8'h00; aLast = 1'b0; aMReady = 1'b1;
    bValid = 1'b0; bData = 8'h00; bLast = 1'b0; bMReady = 1'b1;
    test_reset();
    test_check_value();
    test_gap();
    test_min_pad();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
